// File: rtl/reservation_station_param.sv
// Parametrised Tomasulo reservation station: NUM_CDB-port operand wakeup with
// allocation bypass, lowest-index issue to one ALU through registered outputs.
module reservation_station_param #(
  parameter int ENTRIES   = 16,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int ROB_TAG_W = 4,
  parameter int NUM_CDB   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [OP_W-1:0]                in_op,
  input  logic [ROB_TAG_W-1:0]           in_Qj,
  input  logic [ROB_TAG_W-1:0]           in_Qk,
  input  logic [DATA_W-1:0]              in_Vj,
  input  logic [DATA_W-1:0]              in_Vk,
  input  logic [DATA_W-1:0]              in_imm,
  input  logic [DATA_W-1:0]              in_pc,
  input  logic [ROB_TAG_W-1:0]           in_rob_tag,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*ROB_TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]      cdb_data,
  output logic                           full,
  output logic [$clog2(ENTRIES+1)-1:0]   free_count,
  output logic                           out_valid,
  output logic [OP_W-1:0]                out_op,
  output logic [DATA_W-1:0]              out_Vj,
  output logic [DATA_W-1:0]              out_Vk,
  output logic [DATA_W-1:0]              out_imm,
  output logic [DATA_W-1:0]              out_pc,
  output logic [ROB_TAG_W-1:0]           out_rob_tag
);
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic                 busy;
    logic [OP_W-1:0]      op;
    logic [ROB_TAG_W-1:0] qj;
    logic [ROB_TAG_W-1:0] qk;
    logic [DATA_W-1:0]    vj;
    logic [DATA_W-1:0]    vk;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic [ROB_TAG_W-1:0] rob_tag;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [DATA_W-1:0]    vj;
    logic [DATA_W-1:0]    vk;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic [ROB_TAG_W-1:0] rob_tag;
  } issue_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] q;
    logic [DATA_W-1:0]    v;
  } opnd_t;

  entry_t            entry_q [ENTRIES];
  entry_t            entry_d [ENTRIES];
  issue_t            out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  busy_cnt;
  logic [IDX_W-1:0]  issue_idx, alloc_idx;
  logic              ready_found, free_found;
  logic              issue_fire, alloc_fire;
  opnd_t             wj, wk, aj, ak;

  // Tag 0 means "value present" and never matches a broadcast.
  function automatic opnd_t snoop(input logic [ROB_TAG_W-1:0]         q,
                                  input logic [DATA_W-1:0]            v,
                                  input logic [NUM_CDB-1:0]           vld,
                                  input logic [NUM_CDB*ROB_TAG_W-1:0] tags,
                                  input logic [NUM_CDB*DATA_W-1:0]    data);
    opnd_t res;
    res.q = q;
    res.v = v;
    // Scan high to low so the lowest matching port is the one that sticks.
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (vld[p] && q != '0 && tags[p*ROB_TAG_W +: ROB_TAG_W] == q) begin
        res.q = '0;
        res.v = data[p*DATA_W +: DATA_W];
      end
    end
    return res;
  endfunction

  always_comb begin
    busy_cnt    = '0;
    ready_found = 1'b0;
    issue_idx   = '0;
    free_found  = 1'b0;
    alloc_idx   = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (entry_q[e].busy) busy_cnt = busy_cnt + CNT_W'(1);
      if (!ready_found && entry_q[e].busy && entry_q[e].qj == '0 && entry_q[e].qk == '0) begin
        ready_found = 1'b1;
        issue_idx   = IDX_W'(e);
      end
      if (!free_found && !entry_q[e].busy) begin
        free_found = 1'b1;
        alloc_idx  = IDX_W'(e);
      end
    end
  end

  assign free_count = CNT_W'(ENTRIES) - busy_cnt;
  assign full       = (free_count == '0);
  assign issue_fire = ena & ready_found;
  assign alloc_fire = in_valid & ena & ~full;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; registered state uses '<=' only.
  always_comb begin
    out_valid_d = issue_fire;
    out_d       = out_q;
    wj          = '0;
    wk          = '0;
    aj          = snoop(in_Qj, in_Vj, cdb_valid, cdb_tag, cdb_data);
    ak          = snoop(in_Qk, in_Vk, cdb_valid, cdb_tag, cdb_data);
    for (int e = 0; e < ENTRIES; e++) begin
      entry_d[e] = entry_q[e];
      if (entry_q[e].busy) begin
        wj = snoop(entry_q[e].qj, entry_q[e].vj, cdb_valid, cdb_tag, cdb_data);
        wk = snoop(entry_q[e].qk, entry_q[e].vk, cdb_valid, cdb_tag, cdb_data);
        entry_d[e].qj = wj.q;
        entry_d[e].vj = wj.v;
        entry_d[e].qk = wk.q;
        entry_d[e].vk = wk.v;
      end
    end
    if (issue_fire) begin
      out_d.op      = entry_q[issue_idx].op;
      out_d.vj      = entry_q[issue_idx].vj;
      out_d.vk      = entry_q[issue_idx].vk;
      out_d.imm     = entry_q[issue_idx].imm;
      out_d.pc      = entry_q[issue_idx].pc;
      out_d.rob_tag = entry_q[issue_idx].rob_tag;
      entry_d[issue_idx].busy = 1'b0;
    end
    // alloc_idx comes from pre-edge busy, so it can never be the slot issuing now.
    if (alloc_fire) begin
      entry_d[alloc_idx].busy    = 1'b1;
      entry_d[alloc_idx].op      = in_op;
      entry_d[alloc_idx].qj      = aj.q;
      entry_d[alloc_idx].vj      = aj.v;
      entry_d[alloc_idx].qk      = ak.q;
      entry_d[alloc_idx].vk      = ak.v;
      entry_d[alloc_idx].imm     = in_imm;
      entry_d[alloc_idx].pc      = in_pc;
      entry_d[alloc_idx].rob_tag = in_rob_tag;
    end
  end

  // NOTE: the whole entry array is reset, not only busy, so stale payload can
  // never show up as X on the issue registers after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) entry_q[e] <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      for (int e = 0; e < ENTRIES; e++) entry_q[e].busy <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int e = 0; e < ENTRIES; e++) entry_q[e] <= entry_d[e];
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_q.op;
  assign out_Vj      = out_q.vj;
  assign out_Vk      = out_q.vk;
  assign out_imm     = out_q.imm;
  assign out_pc      = out_q.pc;
  assign out_rob_tag = out_q.rob_tag;

endmodule

// File: doc/reservation_station_param.md
Name: reservation_station_param

Overview:
Parametrised successor to the team's single-CDB reservation station in the Tomasulo out-of-order core. Sits between the decoder/dispatch stage and one ALU.
- Holds up to ENTRIES pending operations.
- Wakes operands from NUM_CDB broadcast buses, including same-cycle bypass on allocation.
- Issues the lowest-index ready entry through a registered valid output.
- Supports a pipeline flush for branch mispredicts.
- Reports free-slot count and full to dispatch.

Parameters:
ENTRIES, 16, number of station slots (>=2)
DATA_W, 32, operand/immediate/PC width
OP_W, 6, operation code width
ROB_TAG_W, 4, ROB tag width; tag 0 means "no dependency / value present"
NUM_CDB, 2, number of CDB broadcast ports

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; asynchronous, active-high
ena  in  1  global enable (low = stall allocation and issue)
flush  in  1  synchronous clear of all entries (mispredict)
in_valid  in  1  dispatch request
in_op  in  OP_W  operation
in_Qj, in_Qk  in  ROB_TAG_W each  source producer tags (0 = ready)
in_Vj, in_Vk  in  DATA_W each  source values (valid when tag 0)
in_imm, in_pc  in  DATA_W each  immediate, instruction PC
in_rob_tag  in  ROB_TAG_W  destination ROB tag
cdb_valid  in  NUM_CDB  per-port broadcast valid
cdb_tag  in  NUM_CDB*ROB_TAG_W  flattened tags, port p at [p*ROB_TAG_W +: ROB_TAG_W]
cdb_data  in  NUM_CDB*DATA_W  flattened data, same packing
full  out  1  no free slot (combinational from registered state)
free_count  out  $clog2(ENTRIES+1)  number of free slots
out_valid  out  1  issue strobe to ALU, one cycle per op
out_op  out  OP_W  issued op
out_Vj, out_Vk, out_imm, out_pc  out  DATA_W each  issued operands
out_rob_tag  out  ROB_TAG_W  issued destination tag

Behaviour:
- Reset (async, any time including mid-operation):
  - All busy bits 0.
  - out_valid, out_op, out_V*, out_imm, out_pc, out_rob_tag all 0.
  - free_count = ENTRIES; full = 0.
- Priority per edge: rst > flush > normal operation.
- flush: all busy cleared, out_valid <= 0, in_valid ignored, CDB ignored.
- Allocation:
  - Accepted when in_valid & ena & ~full.
  - Target slot is the lowest-index non-busy slot, computed from pre-edge busy.
  - in_valid while full or ena=0 is dropped silently; dispatch must gate on full.
- Allocation bypass: if in_Qj (or in_Qk) is nonzero and equals a valid CDB tag in the same cycle, store Q=0 and V=that cdb_data.
- Wakeup:
  - Every edge, regardless of ena, each busy entry with a nonzero Qj/Qk equal to a valid cdb_tag sets Q to 0 and V to cdb_data.
  - Qj and Qk may wake on the same or different ports in the same cycle.
  - A CDB tag of 0 never matches.
  - If multiple ports carry the same tag, the lowest port index wins.
- Ready condition: busy & Qj==0 & Qk==0, evaluated on registered state. Wakeup and allocation take effect the following cycle.
- Issue:
  - When ena, select the lowest-index ready entry.
  - At the edge, load the out_* registers, set out_valid=1 and clear that entry's busy.
  - With no ready entry or ena=0, out_valid <= 0 and out_* hold their previous values.
- Latency:
  - Allocation with both operands ready at edge N -> out_valid high after edge N+1.
  - Wakeup at edge N -> earliest issue at edge N+1.
- Allocation and issue in the same cycle are both performed. A slot freed by issue is not reusable until the next cycle.
- free_count = ENTRIES - popcount(busy); full = (free_count == 0).
- Full boundary: allocation and issue in the same cycle with one free slot leaves free_count unchanged.

Test Plan:
- Reset asserted mid-stream with 5 entries busy -> immediately out_valid=0, free_count=16, full=0; no issue after release until a new dispatch.
- Dispatch op with Qj=0, Qk=0, Vj=5, Vk=7, rob_tag=3 at edge 0 -> out_valid=1 after edge 1 with out_Vj=5, out_Vk=7, out_rob_tag=3; free_count back to 16 after edge 1.
- Dispatch Qj=4, Qk=6; CDB port0 tag4 data 0x11 at edge 2, port1 tag6 data 0x22 at edge 4 -> no issue until after edge 5; out_Vj=0x11, out_Vk=0x22.
- Dispatch Qj=9 while cdb port1 broadcasts tag9 data 0xAB in the same cycle -> issue one cycle later with out_Vj=0xAB (bypass).
- Fill all 16 slots with Qj=2 -> full=1; a 17th dispatch is dropped. Broadcast tag 2 -> entries issue in index order 1 per cycle; full drops to 0 after the first issue.
- With 3 busy entries, assert flush together with in_valid and a matching CDB -> next cycle free_count=16, out_valid=0, nothing issues afterwards.
